picosoc_iobus: RTL and testbench

- Parametrised, registered I/O bus fabric behind the CPU memory interface. Decodes a contiguous window into NUM_SLAVES equal slots, then runs one transaction at a time to the selected slave.
- Adds per-transaction timeout, error responses and an error status slot.
- Sits between the CPU memory bus and on-chip peripherals, replacing ad-hoc per-register select decode.

---
 rtl/picosoc_iobus_pkg.sv | 7 +
 rtl/picosoc_iobus_decode.sv | 25 ++
 rtl/picosoc_iobus.sv | 142 ++++++++++++++
 tb/tb_picosoc_iobus.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/picosoc_iobus_pkg.sv
// picosoc_iobus_pkg: shared FSM states, status-slot offsets and counter width for the I/O bus.
package picosoc_iobus_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    localparam int STAT_ERR_ADDR  = 0;
    localparam int STAT_ERR_COUNT = 4;
    localparam int ERR_COUNT_W    = 16;
endpackage

// File: rtl/picosoc_iobus_decode.sv
// picosoc_iobus_decode: combinational window match and slot classification of a bus address.
module picosoc_iobus_decode
    import picosoc_iobus_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          SLOT_LOG2  = 16,
    parameter int          IDX_W      = $clog2(NUM_SLAVES + 1)
) (
    input  logic [31:SLOT_LOG2] addr,
    output logic                in_window,
    output logic [IDX_W-1:0]    slot,
    output logic                is_slave,
    output logic                is_status,
    output logic                is_unmapped
);
    localparam int               HI = SLOT_LOG2 + IDX_W;
    localparam logic [IDX_W-1:0] NS = IDX_W'(NUM_SLAVES);

    assign in_window   = addr[31:HI] == BASE_ADDR[31:HI];
    assign slot        = addr[SLOT_LOG2 +: IDX_W];
    assign is_slave    = in_window && slot < NS;
    assign is_status   = in_window && slot == NS;
    assign is_unmapped = in_window && slot > NS;
endmodule

// File: rtl/picosoc_iobus.sv
// picosoc_iobus: registered single-outstanding I/O fabric with slot decode, timeout and error status slot.
module picosoc_iobus
    import picosoc_iobus_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter int          SLOT_LOG2      = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          TO_W           = 8,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [31:0]                m_addr,
    input  logic [3:0]                 m_wstrb,
    input  logic [31:0]                m_wdata,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic [31:0]                s_addr,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_wdata,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    output logic                       err_irq
);
    localparam int IDX_W = $clog2(NUM_SLAVES + 1);

    state_t                  state, state_d;
    logic [TO_W-1:0]         cnt, cnt_d;
    logic [NUM_SLAVES-1:0]   s_valid_d;
    logic [31:0]             rdata_q, rdata_d, err_addr, err_addr_d, sel_rdata;
    logic [ERR_COUNT_W-1:0]  err_count, err_count_d, err_count_inc;
    logic                    err_q, err_d, latch, hit;
    logic                    in_window, is_slave, is_status, is_unmapped;
    logic [IDX_W-1:0]        slot;
    logic [SLOT_LOG2-1:0]    off;

    picosoc_iobus_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_LOG2 (SLOT_LOG2),
        .IDX_W     (IDX_W)
    ) u_decode (
        .addr       (m_addr[31:SLOT_LOG2]),
        .in_window  (in_window),
        .slot       (slot),
        .is_slave   (is_slave),
        .is_status  (is_status),
        .is_unmapped(is_unmapped)
    );

    assign off           = m_addr[SLOT_LOG2-1:0];
    assign hit           = |(s_ready & s_valid);
    assign err_count_inc = &err_count ? err_count : err_count + 1'b1;
    assign m_ready       = state == DONE;
    assign m_rdata       = m_ready ? rdata_q : '0;
    assign err_irq       = err_q;

    // s_valid is one-hot, so it doubles as the read-data select
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (s_valid[i]) sel_rdata |= s_rdata[32*i +: 32];
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        s_valid_d   = s_valid;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        err_addr_d  = err_addr;
        err_count_d = err_count;
        latch       = 1'b0;
        case (state)
            IDLE: if (m_valid && in_window) begin
                latch   = 1'b1;
                state_d = DONE;
                if (is_slave) begin
                    s_valid_d = NUM_SLAVES'(1) << slot;
                    cnt_d     = '0;
                    state_d   = ACTIVE;
                end else if (is_status) begin
                    rdata_d = m_wstrb != 4'b0 ? '0 :
                              off == SLOT_LOG2'(STAT_ERR_ADDR)  ? err_addr :
                              off == SLOT_LOG2'(STAT_ERR_COUNT) ? 32'(err_count) : '0;
                    if (m_wstrb != 4'b0 && off == SLOT_LOG2'(STAT_ERR_COUNT)) err_count_d = '0;
                end else if (is_unmapped) begin
                    err_d       = 1'b1;
                    err_addr_d  = m_addr;
                    err_count_d = err_count_inc;
                    rdata_d     = ERR_RDATA;
                end
            end
            ACTIVE: if (hit) begin
                rdata_d   = s_wstrb != 4'b0 ? '0 : sel_rdata;
                s_valid_d = '0;
                state_d   = DONE;
            end else if (cnt == TO_W'(TIMEOUT_CYCLES)) begin
                s_valid_d   = '0;
                err_d       = 1'b1;
                err_addr_d  = s_addr;
                err_count_d = err_count_inc;
                rdata_d     = ERR_RDATA;
                state_d     = DONE;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            s_valid   <= '0;
            s_addr    <= '0;
            s_wstrb   <= '0;
            s_wdata   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            s_valid   <= s_valid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_addr  <= err_addr_d;
            err_count <= err_count_d;
            if (latch) begin
                s_addr  <= m_addr;
                s_wstrb <= m_wstrb;
                s_wdata <= m_wdata;
            end
        end
    end
endmodule

// File: tb/tb_picosoc_iobus.sv
// tb_picosoc_iobus: directed and randomized transactions against a transaction-level model of the bus.
module tb_picosoc_iobus;
    localparam int          NS   = 4;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic             clk = 1'b0;
    logic             resetn;
    logic             m_valid, m_ready, err_irq;
    logic [31:0]      m_addr, m_wdata, m_rdata, s_addr, s_wdata;
    logic [3:0]       m_wstrb, s_wstrb;
    logic [NS-1:0]    s_valid, s_ready;
    logic [32*NS-1:0] s_rdata;

    int          checks = 0, passed = 0, fails = 0;
    logic [31:0] mdl_err_addr;
    int          mdl_err_count;

    picosoc_iobus #(.NUM_SLAVES(NS), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wstrb(s_wstrb),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // rdy: cycle in which the selected slave raises ready; 0 means never
    task automatic txn(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                       input int rdy, input logic [31:0] srd);
        int          slot, off, resp;
        bit          slave, status, err;
        logic [31:0] exp, onehot;
        slot   = int'(addr[18:16]);
        off    = int'(addr[15:0]);
        slave  = slot < NS;
        status = slot == NS;
        onehot = slave ? 32'd1 << slot : 32'd0;
        if (slave) begin
            err  = !(rdy >= 1 && rdy <= TO + 1);
            resp = err ? TO + 2 : rdy + 1;
        end else begin
            err  = !status;
            resp = 1;
        end
        exp = err ? 32'hFFFF_FFFF : ws != 0 ? 32'd0 : slave ? srd :
              off == 0 ? mdl_err_addr : off == 4 ? 32'(mdl_err_count) : 32'd0;
        m_valid = 1'b1; m_addr = addr; m_wstrb = ws; m_wdata = wd; s_ready = '0;
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (slave) s_rdata[32*slot +: 32] = srd;
        for (int c = 1; c <= resp; c++) begin
            @(negedge clk);
            chk("m_ready", 32'(m_ready), 32'(c == resp));
            chk("s_valid", 32'(s_valid), (slave && c < resp) ? onehot : 32'd0);
            chk("err_irq", 32'(err_irq), 32'(c == resp && err));
            if (c == resp) chk("m_rdata", m_rdata, exp);
            if (c == 1 && slave) begin
                chk("s_addr", s_addr, addr);
                chk("s_wstrb", 32'(s_wstrb), 32'(ws));
                chk("s_wdata", s_wdata, wd);
            end
            s_ready = NS'($urandom) & ~NS'(onehot);
            if (slave && rdy >= 1 && c >= rdy) s_ready |= NS'(onehot);
            if (c == resp) begin m_valid = 1'b0; s_ready = '0; end
        end
        if (err) begin
            mdl_err_addr = addr;
            if (mdl_err_count < 16'hFFFF) mdl_err_count++;
        end
        if (status && ws != 0 && off == 4) mdl_err_count = 0;
        @(negedge clk);
        chk("idle_m_ready", 32'(m_ready), 32'd0);
        chk("idle_m_rdata", m_rdata, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; m_valid = 1'b0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
        s_ready = '0; s_rdata = '0;
        mdl_err_addr = '0; mdl_err_count = 0;
        repeat (2) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_err_irq", 32'(err_irq), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        txn(BASE + 32'h1_0010, 4'b0000, 32'h0, 2, 32'h1234_5678);
        txn(BASE + 32'h2_0000, 4'b0100, 32'h00AB_0000, 1, 32'hDEAD_BEEF);
        txn(BASE + 32'h3_0008, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0000, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0004, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h5_0000, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0004, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0004, 4'b0001, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0004, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0008, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h0_0004, 4'b0000, 32'h0, TO + 1, 32'hCAFE_F00D);

        m_valid = 1'b1; m_addr = 32'h0200_0004; m_wstrb = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("oow_m_ready", 32'(m_ready), 32'd0);
            chk("oow_s_valid", 32'(s_valid), 32'd0);
        end
        m_valid = 1'b0;
        @(negedge clk);

        m_valid = 1'b1; m_addr = BASE + 32'h3_0000; m_wstrb = '0; s_ready = '0;
        repeat (3) @(negedge clk);
        chk("pre_rst_s_valid", 32'(s_valid), 32'h8);
        resetn = 1'b0;
        #1;
        chk("async_s_valid", 32'(s_valid), 32'd0);
        chk("async_m_ready", 32'(m_ready), 32'd0);
        mdl_err_addr = '0; mdl_err_count = 0;
        m_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        txn(BASE + 32'h0_0000, 4'b0000, 32'h0, 3, 32'h0BAD_CAFE);
        txn(BASE + 32'h4_0000, 4'b0000, 32'h0, 0, 32'h0);
        txn(BASE + 32'h4_0004, 4'b0000, 32'h0, 0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [3:0]  ws;
            int          slot;
            slot = $urandom_range(0, 7);
            a = BASE | (32'(slot) << 16);
            a[15:0] = (slot == NS) ? 16'($urandom_range(0, 3) * 4) : 16'($urandom) & 16'hFFFC;
            ws = $urandom_range(0, 1) ? 4'b0 : 4'($urandom_range(1, 15));
            txn(a, ws, $urandom, $urandom_range(0, TO + 3), $urandom);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
